msx_cas_encoder: RTL

MSX_CAS_ENCODER -- requirements
Module: msx_cas_encoder

---
 rtl/msx_cas_encoder_if.sv | 11 +
 rtl/msx_cas_encoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/msx_cas_encoder_if.sv
// Command handshake between a cassette-encoder client and msx_cas_encoder.
interface msx_cas_encoder_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_hdr;
  logic       cmd_long;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, cmd_hdr, cmd_long, cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, cmd_hdr, cmd_long, cmd_data, output cmd_ready);
endinterface

// File: rtl/msx_cas_encoder.sv
// MSX cassette FSK encoder: emits leader tones or 11-bit byte frames on cas_out.
module msx_cas_encoder #(
  parameter int unsigned CLK_HZ = 21477272
) (
  input  logic             clk_sys,
  input  logic             reset,
  msx_cas_encoder_if.slave cmd,
  input  logic             baud,
  output logic             cas_out,
  output logic             busy
);
  localparam int unsigned H  = CLK_HZ / 9600;
  localparam int unsigned CW = ($clog2(4*H + 1) > 14) ? $clog2(4*H + 1) : 14;
  localparam logic [CW-1:0] P1_SLOW = CW'(2*H);
  localparam logic [CW-1:0] P1_FAST = CW'(H);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [1:0] {IDLE, HDR, BYTE} state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] half_q, half_n;
  logic [14:0]   cyc_q, cyc_n;
  logic [10:0]   frame_q, frame_n;
  logic [3:0]    bit_q, bit_n;
  logic          sub_q, sub_n;
  logic          baud_q, baud_n;
  logic          cas_n, busy_n;
  logic [CW-1:0] p1_cur, p0_cur, p1_in, half_len;
  logic [14:0]   lead_last;

  assign cmd.cmd_ready = ~busy;

  always_comb begin
    p1_cur = baud_q ? P1_FAST : P1_SLOW;
    p0_cur = p1_cur << 1;
    p1_in  = baud ? P1_FAST : P1_SLOW;
    // Leader lengths stored as N-1 so the counter ends at zero.
    case ({baud, cmd.cmd_long})
      2'b00:   lead_last = 15'd3999;
      2'b01:   lead_last = 15'd15999;
      2'b10:   lead_last = 15'd7999;
      default: lead_last = 15'd31999;
    endcase
    half_len = (state_q == BYTE && !frame_q[0]) ? p0_cur : p1_cur;
  end

  always_comb begin
    state_n = state_q;
    half_n  = half_q;
    cyc_n   = cyc_q;
    frame_n = frame_q;
    bit_n   = bit_q;
    sub_n   = sub_q;
    baud_n  = baud_q;
    cas_n   = cas_out;
    busy_n  = busy;
    case (state_q)
      IDLE: begin
        if (cmd.cmd_valid) begin
          baud_n = baud;
          cas_n  = 1'b1;
          busy_n = 1'b1;
          if (cmd.cmd_hdr) begin
            state_n = HDR;
            cyc_n   = lead_last;
            half_n  = p1_in - ONE;
          end else begin
            state_n = BYTE;
            frame_n = {2'b11, cmd.cmd_data, 1'b0};
            bit_n   = 4'd0;
            sub_n   = 1'b0;
            half_n  = (p1_in << 1) - ONE;
          end
        end
      end
      HDR, BYTE: begin
        if (half_q != '0) begin
          half_n = half_q - ONE;
        end else if (cas_out) begin
          cas_n  = 1'b0;
          half_n = half_len - ONE;
        end else if (state_q == HDR) begin
          if (cyc_q == '0) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end else begin
            cyc_n  = cyc_q - 15'd1;
            cas_n  = 1'b1;
            half_n = p1_cur - ONE;
          end
        end else if (frame_q[0] && !sub_q) begin
          // A 1-bit is two short cycles; the first just re-arms the same bit.
          sub_n  = 1'b1;
          cas_n  = 1'b1;
          half_n = p1_cur - ONE;
        end else if (bit_q == 4'd10) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else begin
          sub_n   = 1'b0;
          frame_n = frame_q >> 1;
          bit_n   = bit_q + 4'd1;
          cas_n   = 1'b1;
          half_n  = (frame_q[1] ? p1_cur : p0_cur) - ONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      half_q  <= '0;
      cyc_q   <= '0;
      frame_q <= '0;
      bit_q   <= '0;
      sub_q   <= 1'b0;
      baud_q  <= 1'b0;
      cas_out <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_n;
      half_q  <= half_n;
      cyc_q   <= cyc_n;
      frame_q <= frame_n;
      bit_q   <= bit_n;
      sub_q   <= sub_n;
      baud_q  <= baud_n;
      cas_out <= cas_n;
      busy    <= busy_n;
    end
  end
endmodule
